// File: rtl/ramdual_bist_pkg.sv
// Shared definitions for the dual-port RAM BIST: FSM state encoding,
// default seed pattern and the pass-select (normal / inverted) constants.
package ramdual_bist_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WRITE = 3'd1,
    ST_READ  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam int unsigned DEF_SEED = 32'h0000_00A5;

  localparam logic PASS_NORM = 1'b0;
  localparam logic PASS_INV  = 1'b1;

endpackage

// File: rtl/ramdual_bist_cmp.sv
// Read-data checker: delays the expected word and address by one cycle to
// line up with registered RAM read data, counts miscompares (saturating)
// and captures the address of the first miscompare.
module ramdual_bist_cmp
  import ramdual_bist_pkg::*;
#(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              chk,
  input  logic [DATA_W-1:0] exp_data,
  input  logic [ADDR_W-1:0] chk_addr,
  input  logic [DATA_W-1:0] dout,
  output logic [ADDR_W:0]   err_cnt,
  output logic [ADDR_W-1:0] fail_addr,
  output logic              err_zero_next
);

  logic              vld_reg;
  logic [DATA_W-1:0] exp_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic              miscmp;
  logic [ADDR_W:0]   err_next;

  // Align expected value and address with the read data arriving next cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_reg  <= 1'b0;
      exp_reg  <= '0;
      addr_reg <= '0;
    end else begin
      vld_reg  <= chk;
      exp_reg  <= exp_data;
      addr_reg <= chk_addr;
    end
  end

  assign miscmp = vld_reg && (dout != exp_reg);

  // Saturating error count; the value about to be loaded is exported so the
  // final compare can be folded into the pass flag on the same edge.
  always_comb begin
    err_next = err_cnt;
    if (miscmp && (err_cnt != '1))
      err_next = err_cnt + 1'b1;
  end

  assign err_zero_next = (err_next == '0);

  // Error count and first-failure address, cleared by reset or a new run.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      err_cnt   <= '0;
      fail_addr <= '0;
    end else begin
      err_cnt <= err_next;
      if (miscmp && (err_cnt == '0))
        fail_addr <= addr_reg;
    end
  end

endmodule

// File: rtl/ramdual_bist.sv
// March-style BIST for a dual-port RAM: write the seed pattern to every
// location, read it all back and compare. Defining RAMDUAL_BIST_INV_EN adds
// a second write/read pass with the inverted pattern.
module ramdual_bist
  import ramdual_bist_pkg::*;
#(
  parameter int          ADDR_W = 4,
  parameter int          DATA_W = 8,
  parameter int unsigned SEED   = DEF_SEED
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [ADDR_W:0]   err_cnt,
  output logic              wren,
  output logic              ren,
  output logic [ADDR_W-1:0] wradd,
  output logic [ADDR_W-1:0] radd,
  output logic [DATA_W-1:0] data,
  input  logic [DATA_W-1:0] dout
);

  localparam logic [DATA_W-1:0] SEED_W = DATA_W'(SEED);

  state_t            state;
  logic [ADDR_W-1:0] cnt;
  logic [ADDR_W-1:0] cnt_inc;
  logic              accept;
  logic              err_zero_next;
  logic [DATA_W-1:0] exp_data;

  function automatic logic [DATA_W-1:0] pat(input logic [ADDR_W-1:0] a);
    return SEED_W ^ DATA_W'(a);
  endfunction

`ifdef RAMDUAL_BIST_INV_EN
  logic inv;

  function automatic logic [DATA_W-1:0] cur_pat(input logic [ADDR_W-1:0] a);
    return (inv == PASS_INV) ? ~pat(a) : pat(a);
  endfunction
`else
  function automatic logic [DATA_W-1:0] cur_pat(input logic [ADDR_W-1:0] a);
    return pat(a);
  endfunction
`endif

  assign cnt_inc  = cnt + 1'b1;
  assign accept   = (state == ST_IDLE) && start;
  assign exp_data = cur_pat(radd);

  // Sequencer: walks WRITE then READ over all addresses, drives the RAM
  // ports from registers and raises done one cycle after the drain compare.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      pass  <= 1'b0;
      wren  <= 1'b0;
      ren   <= 1'b0;
      wradd <= '0;
      radd  <= '0;
      data  <= '0;
`ifdef RAMDUAL_BIST_INV_EN
      inv   <= PASS_NORM;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            state <= ST_WRITE;
            cnt   <= '0;
            busy  <= 1'b1;
            pass  <= 1'b0;
            wren  <= 1'b1;
            wradd <= '0;
            data  <= pat('0);
`ifdef RAMDUAL_BIST_INV_EN
            inv   <= PASS_NORM;
`endif
          end
        end
        ST_WRITE: begin
          if (cnt == '1) begin
            state <= ST_READ;
            cnt   <= '0;
            wren  <= 1'b0;
            wradd <= '0;
            data  <= '0;
            ren   <= 1'b1;
            radd  <= '0;
          end else begin
            cnt   <= cnt_inc;
            wradd <= cnt_inc;
            data  <= cur_pat(cnt_inc);
          end
        end
        ST_READ: begin
          if (cnt == '1) begin
            state <= ST_DRAIN;
            cnt   <= '0;
            ren   <= 1'b0;
            radd  <= '0;
          end else begin
            cnt  <= cnt_inc;
            radd <= cnt_inc;
          end
        end
        ST_DRAIN: begin
`ifdef RAMDUAL_BIST_INV_EN
          if (inv == PASS_NORM) begin
            state <= ST_WRITE;
            inv   <= PASS_INV;
            cnt   <= '0;
            wren  <= 1'b1;
            wradd <= '0;
            data  <= ~pat('0);
          end else
`endif
          begin
            state <= ST_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= err_zero_next;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          done  <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
          wren  <= 1'b0;
          ren   <= 1'b0;
        end
      endcase
    end
  end

  ramdual_bist_cmp #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_cmp (
    .clk          (clk),
    .rst          (rst),
    .clr          (accept),
    .chk          (ren),
    .exp_data     (exp_data),
    .chk_addr     (radd),
    .dout         (dout),
    .err_cnt      (err_cnt),
    .fail_addr    (fail_addr),
    .err_zero_next(err_zero_next)
  );

endmodule

// File: tb/tb_ramdual_bist.sv
// Bench for ramdual_bist with a faultable 16x8 RAM model. Expected bus
// activity and results come from the pattern/timing rules, evaluated per
// cycle; expected errors come from simulating what each fault does to the
// stored pattern. Works with or without RAMDUAL_BIST_INV_EN.
module tb_ramdual_bist;

  localparam int AW     = 4;
  localparam int DW     = 8;
  localparam int N      = 16;
  localparam int SEED_T = 'hA5;
`ifdef RAMDUAL_BIST_INV_EN
  localparam int NP = 2;
`else
  localparam int NP = 1;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          busy, done, pass, wren, ren;
  logic [AW-1:0] fail_addr, wradd, radd;
  logic [AW:0]   err_cnt;
  logic [DW-1:0] data;
  logic [DW-1:0] dout = '0;

  logic [DW-1:0] mem  [N];
  logic [DW-1:0] s0   [N];
  logic [DW-1:0] s1   [N];
  logic [DW-1:0] flip [N];

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  ramdual_bist #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .pass(pass), .fail_addr(fail_addr), .err_cnt(err_cnt), .wren(wren),
    .ren(ren), .wradd(wradd), .radd(radd), .data(data), .dout(dout)
  );

  function automatic logic [DW-1:0] pat(input int a);
    return 8'(SEED_T ^ a);
  endfunction

  function automatic logic [DW-1:0] stored(input int a, input logic [DW-1:0] d);
    return ((d ^ flip[a]) & ~s0[a]) | s1[a];
  endfunction

  // Faultable RAM: registered read, faults applied on the write path.
  always @(posedge clk) begin
    if (wren) mem[wradd] <= stored(int'(wradd), data);
    if (ren)  dout <= mem[radd];
  end

  task automatic clear_faults();
    for (int a = 0; a < N; a++) begin
      s0[a] = '0; s1[a] = '0; flip[a] = '0;
    end
  endtask

  // Launch one run and check every cycle against the rule-derived schedule.
  task automatic run_bist(input string name, input int repulse_at, input int rst_at);
    int errs, exp_fail, exp_err, done_cyc, p, l;
    bit got;
    logic [DW-1:0] w;
    logic [2*AW+DW+3:0] obs, expv;
    logic [AW+AW+1:0] robs, rexp;
    logic ew, er, eb, edn, epass;
    logic [AW-1:0] ewa, era;
    logic [DW-1:0] ed;
    errs = 0; exp_fail = 0; got = 0;
    for (int pp = 0; pp < NP; pp++)
      for (int a = 0; a < N; a++) begin
        w = (pp == 1) ? ~pat(a) : pat(a);
        if (stored(a, w) != w) begin
          if (!got) begin exp_fail = a; got = 1; end
          errs++;
        end
      end
    exp_err  = (errs > 31) ? 31 : errs;
    done_cyc = NP * (2 * N + 1) + 1;
    @(negedge clk); start = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= done_cyc + 4; c++) begin
      @(negedge clk);
      start = 1'b0; rst = 1'b0;
      ew = 0; er = 0; eb = 0; edn = 0; ewa = '0; era = '0; ed = '0;
      if (rst_at == 0 || c <= rst_at) begin
        if (c <= NP * (2 * N + 1)) begin
          eb = 1;
          p  = (c - 1) / (2 * N + 1);
          l  = c - p * (2 * N + 1);
          if (l <= N) begin
            ew = 1; ewa = AW'(l - 1); ed = (p == 1) ? ~pat(l - 1) : pat(l - 1);
          end else if (l <= 2 * N) begin
            er = 1; era = AW'(l - N - 1);
          end
        end
        edn = (c == done_cyc);
      end
      obs  = {busy, done, wren, ren, wradd, radd, data};
      expv = {eb, edn, ew, er, ewa, era, ed};
      vectors++;
      if (obs !== expv) begin
        miscompares++;
        $display("FAIL %s bus c=%0d: got busy=%b done=%b wren=%b ren=%b wradd=%h radd=%h data=%h, want busy=%b done=%b wren=%b ren=%b wradd=%h radd=%h data=%h",
                 name, c, busy, done, wren, ren, wradd, radd, data, eb, edn, ew, er, ewa, era, ed);
      end
      if (rst_at != 0 && c > rst_at) begin
        rexp = '0;
      end else if (c >= done_cyc) begin
        epass = (errs == 0);
        rexp = {epass, (AW+1)'(exp_err), AW'(exp_fail)};
      end else begin
        rexp = {1'b0, err_cnt, fail_addr};
      end
      robs = {pass, err_cnt, fail_addr};
      if ((rst_at != 0 && c > rst_at) || c >= done_cyc || pass !== 1'b0) begin
        vectors++;
        if (robs !== rexp) begin
          miscompares++;
          $display("FAIL %s result c=%0d: got pass=%b err_cnt=%0d fail_addr=%h, want pass=%b err_cnt=%0d fail_addr=%h",
                   name, c, pass, err_cnt, fail_addr, rexp[2*AW+1], rexp[2*AW:AW], rexp[AW-1:0]);
        end
      end
      start = (c == repulse_at);
      rst   = (c == rst_at);
    end
    @(negedge clk); start = 1'b0; rst = 1'b0;
    $display("run %s: model errors=%0d err_cnt=%0d fail_addr=%h pass=%b", name, errs, err_cnt, fail_addr, pass);
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    vectors++;
    if ({busy, done, pass, fail_addr, err_cnt, wren, ren, wradd, radd, data} !== '0) begin
      miscompares++;
      $display("FAIL reset: got busy=%b done=%b pass=%b fail_addr=%h err_cnt=%h wren=%b ren=%b wradd=%h radd=%h data=%h, want all 0",
               busy, done, pass, fail_addr, err_cnt, wren, ren, wradd, radd, data);
    end
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    $display("run reset: outputs idle");
  endtask

  task automatic test_clean();
    clear_faults();
    run_bist("clean", 0, 0);
  endtask

  task automatic test_single_fault();
    clear_faults();
    s0[10] = 8'h01;
    run_bist("stuck0_addrA_bit0", 0, 0);
    clear_faults();
    s0[3] = 8'h02;
    run_bist("stuck0_addr3_bit1", 0, 0);
  endtask

  task automatic test_restart_ignored();
    clear_faults();
    run_bist("repulse_k10", 10, 0);
    run_bist("start_in_done", NP * (2 * N + 1) + 1, 0);
  endtask

  task automatic test_mid_reset();
    clear_faults();
    run_bist("reset_mid_write", 0, 5);
    run_bist("reset_mid_read", 0, N + 7);
    run_bist("after_reset", 0, 0);
  endtask

  task automatic test_all_faulty();
    clear_faults();
    for (int a = 0; a < N; a++) flip[a] = 8'h10;
    run_bist("all_faulty", 0, 0);
  endtask

  task automatic test_random();
    int a, b, k;
    for (int it = 0; it < 6; it++) begin
      clear_faults();
      for (int f = 0; f < 3; f++) begin
        a = $urandom_range(0, N - 1);
        b = $urandom_range(0, DW - 1);
        k = $urandom_range(0, 3);
        case (k)
          0: s0[a]   = s0[a]   | (8'h01 << b);
          1: s1[a]   = s1[a]   | (8'h01 << b);
          2: flip[a] = flip[a] | (8'h01 << b);
          default: ;
        endcase
      end
      run_bist($sformatf("random_%0d", it), 0, 0);
    end
  endtask

  initial begin
    clear_faults();
    for (int a = 0; a < N; a++) mem[a] = '0;
    test_reset();
    test_clean();
    test_single_fault();
    test_restart_ignored();
    test_mid_reset();
    test_all_faulty();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
